// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the fetch stage
//   and the MEM stage. One requester is granted at a time; the winner's
//   address/data are latched and held for a fixed MEM_LAT-cycle access, the
//   read word is captured in the last access cycle, and the owner's done
//   output pulses for exactly one cycle afterwards.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request (level) and address
//   if_done/if_rdata         fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_done/d_rdata           data completion pulse and load word
//   mem_sel                  mux select toward memory: 0 = fetch, 1 = data
//   mem_en/mem_we            memory enable / write enable
//   mem_addr/mem_wdata       latched address / store data toward memory
//   mem_rdata                memory read data
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter preload: BUSY spans MEM_LAT cycles, counting down to zero.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              last_d_r, last_d_nxt_s;
  logic              grant_d_s;
  logic              sel_nxt_s, en_nxt_s, we_nxt_s;
  logic              if_done_nxt_s, d_done_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [DATA_W-1:0] wdata_nxt_s, if_rdata_nxt_s, d_rdata_nxt_s;

  // Data wins a tie unless it won the previous grant (alternating fairness).
  assign grant_d_s = d_req & (~if_req | ~last_d_r);

  // Next-state and next-output logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    last_d_nxt_s   = last_d_r;
    sel_nxt_s      = mem_sel;
    en_nxt_s       = 1'b0;
    we_nxt_s       = 1'b0;
    addr_nxt_s     = mem_addr;
    wdata_nxt_s    = mem_wdata;
    if_done_nxt_s  = 1'b0;
    d_done_nxt_s   = 1'b0;
    if_rdata_nxt_s = if_rdata;
    d_rdata_nxt_s  = d_rdata;
    case (state_r)
      IDLE: begin
        if (if_req | d_req) begin
          state_nxt_s  = BUSY;
          cnt_nxt_s    = LAT_M1;
          last_d_nxt_s = grant_d_s;
          sel_nxt_s    = grant_d_s;
          en_nxt_s     = 1'b1;
          if (grant_d_s) begin
            we_nxt_s    = d_we;
            addr_nxt_s  = d_addr;
            wdata_nxt_s = d_wdata;
          end else begin
            we_nxt_s    = 1'b0;
            addr_nxt_s  = if_addr;
            wdata_nxt_s = {DATA_W{1'b0}};
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          // Last access cycle: memory data is valid now, hand it to the owner.
          state_nxt_s = DONE;
          if (!mem_sel) begin
            if_rdata_nxt_s = mem_rdata;
            if_done_nxt_s  = 1'b1;
          end else begin
            d_done_nxt_s = 1'b1;
            if (!mem_we) begin
              d_rdata_nxt_s = mem_rdata;
            end else begin
              d_rdata_nxt_s = d_rdata;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
          en_nxt_s  = 1'b1;
          we_nxt_s  = mem_we;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs; reset aborts any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      last_d_r  <= 1'b0;
      mem_sel   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= {DATA_W{1'b0}};
      d_rdata   <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      last_d_r  <= last_d_nxt_s;
      mem_sel   <= sel_nxt_s;
      mem_en    <= en_nxt_s;
      mem_we    <= we_nxt_s;
      mem_addr  <= addr_nxt_s;
      mem_wdata <= wdata_nxt_s;
      if_done   <= if_done_nxt_s;
      d_done    <= d_done_nxt_s;
      if_rdata  <= if_rdata_nxt_s;
      d_rdata   <= d_rdata_nxt_s;
    end
  end

endmodule
